de_skid_register: RTL and testbench
===================================

# de_skid_register

Parametrised fetch-to-decode pipeline register for the LC-3b pipeline. It replaces the load-enable IF/DE latch with a ready/valid handshake, an optional one-entry skid buffer and a synchronous flush. With the skid buffer, fetch can keep streaming for one cycle after execute stalls, and `in_ready` carries no combinational path from `out_ready`. It sits between instruction fetch (PC+2, I-cache read data) and the decode/register-file stage.

## Interface
Parameters:
- `WORD_WIDTH`, 16, width of the carried PC+2 value.
- `SKID`, 1, 1 = two-entry skid mode; 0 = single-entry stall register.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  register accepts this cycle.
- `in_pc_plus2`  in  WORD_WIDTH  PC+2 of the fetched instruction.
- `in_instr`  in  16  instruction word (`lc3b_word`).
- `flush`  in  1  kill all held entries (branch/trap redirect).
- `out_ready`  in  1  decode/execute consumes this cycle.
- `out_valid`  out  1  head entry holds a live instruction.
- `out_pc_plus2`  out  WORD_WIDTH  head entry PC+2.
- `out_ir`  out  16  head entry instruction word.
- `opcode` (`lc3b_opcode`), `dest`/`src1`/`src2` (`lc3b_reg`)  out  decoded from `out_ir`: [15:12], [11:9], [8:6], [2:0].
- `ir3`, `ir4`, `ir5`, `ir8`, `ir11`  out  1 each  `out_ir` bits 3, 4, 5, 8, 11.
- `occupancy`  out  2  live entries held (0–2).

## Operation
- Storage: main entry M (head, drives outputs) and skid entry S (`SKID`=1 only). Each entry has a valid bit, PC+2 and IR.
- Accept = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- `out_valid` = M.valid. Decoded fields are combinational from M.IR and are meaningful only when `out_valid`=1.
- `SKID`=1: `in_ready` = !S.valid, registered state only.
- `SKID`=0: `in_ready` = !M.valid || `out_ready`, combinational.
- State machine (`de_occ_t`):
  - EMPTY: accept → ONE, M←in.
  - ONE, accept & pop → ONE, M←in.
  - ONE, accept & !pop → FULL, S←in. This transition is used only when `SKID`=1. With `SKID`=0, `in_ready`=0 in this case.
  - ONE, pop & !accept → EMPTY.
  - FULL: `in_ready`=0. Pop → ONE, M←S. No pop → hold.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush has priority over everything. Next state is EMPTY and both valid bits clear. An accept in the flush cycle is discarded: fetch sees the handshake complete, but the instruction dies. A pop in the flush cycle is still a completed handshake, and downstream is responsible for its own kill. PC/IR data registers keep their contents on flush.
- Reset: state EMPTY, valid bits 0, all PC/IR data registers 0. Reset takes priority over flush.
- Reset values at outputs:
  - `out_valid`=0, `occupancy`=0.
  - `in_ready`=1 in both modes.
  - `out_ir`=0, `out_pc_plus2`=0, `opcode`=0 (BR), all reg/bit fields 0.

## Timing
- Latency: accept in cycle N → `out_valid`=1 with that data in cycle N+1 (EMPTY or ONE-with-pop).
- Throughput: 1 instruction/cycle with `out_ready` held high.
- After the first stall cycle in ONE, `in_ready` falls in the next cycle (FULL). It rises one cycle after the pop from FULL.
- `out_*` and decoded fields change only at clock edges. Decoded fields are combinational from M only.
- Flush or reset asserted in cycle N → `out_valid`=0 and `occupancy`=0 in cycle N+1. An accept in N+1 is legal.

## Structure
- Add `de_occ_t` enum {DE_EMPTY, DE_ONE, DE_FULL} to `lc3b_types`. Reuse `lc3b_word`, `lc3b_reg` and `lc3b_opcode` from the same package.
- One sub-module: `de_entry` (valid + PC+2 + IR register with load, synchronous clear of valid, synchronous reset of data). Instantiate it twice. Generate the S instance only if `SKID`=1.
- Field decode is inline combinational logic on M.IR.

## Test plan
- Reset, then stream 0x1000/0x1002/0x1004 with `out_ready`=1 → each appears one cycle later in order; `in_ready` stays 1; `occupancy`=1.
- `SKID`=1: with A in M, drop `out_ready` while B is accepted → `occupancy`=2 and `in_ready`=0 next cycle. Raise `out_ready` → A then B pop on consecutive cycles; `in_ready` returns 1 after the A pop.
- `SKID`=0: same stall → `in_ready` drops combinationally with `out_ready`=0 while M is valid; no entry is lost.
- Flush while FULL with a concurrent `in_valid` → next cycle `out_valid`=0, `occupancy`=0; the flushed-cycle instruction never appears.
- `in_instr`=0x1283 (ADD R1,R2,R3) → `opcode`=ADD, `dest`=1, `src1`=2, `src2`=3, `ir5`=0. `in_instr`=0x0E05 → `ir11`=1, `opcode`=BR.
- Reset asserted mid-stall with `occupancy`=2 → next cycle all outputs equal their reset values; the next accepted instruction flows normally.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, register index, opcode and decode-register occupancy.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    OpBr  = 4'h0,
    OpAdd = 4'h1,
    OpLdb = 4'h2,
    OpStb = 4'h3,
    OpJsr = 4'h4,
    OpAnd = 4'h5,
    OpLdr = 4'h6,
    OpStr = 4'h7,
    OpRti = 4'h8,
    OpNot = 4'h9,
    OpLdi = 4'ha,
    OpSti = 4'hb,
    OpJmp = 4'hc,
    OpShf = 4'hd,
    OpLea = 4'he,
    OpTrap = 4'hf
  } lc3b_opcode;

  // Fetch-to-decode register fill level.
  typedef enum logic [1:0] {
    DE_EMPTY = 2'd0,
    DE_ONE   = 2'd1,
    DE_FULL  = 2'd2
  } de_occ_t;

  // Number of live entries for a given fill state.
  function automatic logic [1:0] occ_count(de_occ_t s);
    logic [1:0] n;
    case (s)
      DE_ONE:  n = 2'd1;
      DE_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/de_entry.sv
// One pipeline-register entry: valid bit plus PC+2 and instruction word.
module de_entry
  import lc3b_types::*;
#(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [WORD_WIDTH-1:0] pc_i,
  input  lc3b_word              ir_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] pc_o,
  output lc3b_word              ir_o
);

  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  lc3b_word              ir_q, ir_d;

  // Load captures data and sets valid; clear only drops valid, data is retained.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      ir_d    = ir_i;
    end
    if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry state with synchronous reset of valid and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign ir_o    = ir_q;

endmodule

// File: rtl/de_skid_register.sv
// Fetch-to-decode pipeline register with ready/valid handshake, optional skid entry and flush.
module de_skid_register
  import lc3b_types::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned SKID       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_pc_plus2,
  input  lc3b_word              in_instr,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_pc_plus2,
  output lc3b_word              out_ir,
  output lc3b_opcode            opcode,
  output lc3b_reg               dest,
  output lc3b_reg               src1,
  output lc3b_reg               src2,
  output logic                  ir3,
  output logic                  ir4,
  output logic                  ir5,
  output logic                  ir8,
  output logic                  ir11,
  output logic [1:0]            occupancy
);

  de_occ_t state_q, state_d;

  logic                  m_valid, m_load, m_clear, m_from_s;
  logic [WORD_WIDTH-1:0] m_pc, m_pc_in;
  lc3b_word              m_ir, m_ir_in;

  logic                  s_valid, s_load, s_clear;
  logic [WORD_WIDTH-1:0] s_pc;
  lc3b_word              s_ir;

  logic accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = m_valid && out_ready;

  // Skid mode decouples in_ready from out_ready; stall mode passes through when draining.
  assign in_ready = (SKID != 0) ? !s_valid : (!m_valid || out_ready);

  // Occupancy transitions and entry load/clear controls; flush overrides all of them.
  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_clear  = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    case (state_q)
      DE_EMPTY: begin
        if (accept) begin
          m_load  = 1'b1;
          state_d = DE_ONE;
        end
      end
      DE_ONE: begin
        if (accept && pop) begin
          m_load = 1'b1;
        end else if (accept) begin
          s_load  = 1'b1;
          state_d = DE_FULL;
        end else if (pop) begin
          m_clear = 1'b1;
          state_d = DE_EMPTY;
        end
      end
      DE_FULL: begin
        if (pop) begin
          m_load   = 1'b1;
          m_from_s = 1'b1;
          s_clear  = 1'b1;
          state_d  = DE_ONE;
        end
      end
      default: state_d = DE_EMPTY;
    endcase
    if (flush) begin
      m_load  = 1'b0;
      s_load  = 1'b0;
      m_clear = 1'b1;
      s_clear = 1'b1;
      state_d = DE_EMPTY;
    end
  end

  // Fill-state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DE_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign m_pc_in = m_from_s ? s_pc : in_pc_plus2;
  assign m_ir_in = m_from_s ? s_ir : in_instr;

  de_entry #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load_i (m_load),
    .clear_i(m_clear),
    .pc_i   (m_pc_in),
    .ir_i   (m_ir_in),
    .valid_o(m_valid),
    .pc_o   (m_pc),
    .ir_o   (m_ir)
  );

  if (SKID != 0) begin : g_skid
    de_entry #(
      .WORD_WIDTH(WORD_WIDTH)
    ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load_i (s_load),
      .clear_i(s_clear),
      .pc_i   (in_pc_plus2),
      .ir_i   (in_instr),
      .valid_o(s_valid),
      .pc_o   (s_pc),
      .ir_o   (s_ir)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_pc    = '0;
    assign s_ir    = '0;
  end

  assign out_valid    = m_valid;
  assign out_pc_plus2 = m_pc;
  assign out_ir       = m_ir;
  assign occupancy    = occ_count(state_q);

  // Field decode straight off the head entry.
  assign opcode = lc3b_opcode'(m_ir[15:12]);
  assign dest   = m_ir[11:9];
  assign src1   = m_ir[8:6];
  assign src2   = m_ir[2:0];
  assign ir3    = m_ir[3];
  assign ir4    = m_ir[4];
  assign ir5    = m_ir[5];
  assign ir8    = m_ir[8];
  assign ir11   = m_ir[11];

endmodule

// File: tb/tb_de_skid_register.sv
// Bench for de_skid_register: skid and stall variants side by side against a FIFO reference.
module tb_de_skid_register;
  import lc3b_types::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [15:0] in_pc_plus2;
  lc3b_word    in_instr;

  // k = 1: skid variant, k = 0: stall variant
  logic        rdy_1, ov_1, i3_1, i4_1, i5_1, i8_1, i11_1;
  logic [15:0] pc_1, ir_1;
  lc3b_opcode  op_1;
  lc3b_reg     dst_1, sa_1, sb_1;
  logic [1:0]  occ_1;
  logic        rdy_0, ov_0, i3_0, i4_0, i5_0, i8_0, i11_0;
  logic [15:0] pc_0, ir_0;
  lc3b_opcode  op_0;
  lc3b_reg     dst_0, sa_0, sb_0;
  logic [1:0]  occ_0;

  de_skid_register #(.WORD_WIDTH(16), .SKID(1)) u_dut_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_1),
    .in_pc_plus2(in_pc_plus2), .in_instr(in_instr), .flush(flush), .out_ready(out_ready),
    .out_valid(ov_1), .out_pc_plus2(pc_1), .out_ir(ir_1), .opcode(op_1), .dest(dst_1),
    .src1(sa_1), .src2(sb_1), .ir3(i3_1), .ir4(i4_1), .ir5(i5_1), .ir8(i8_1), .ir11(i11_1),
    .occupancy(occ_1)
  );

  de_skid_register #(.WORD_WIDTH(16), .SKID(0)) u_dut_stall (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_0),
    .in_pc_plus2(in_pc_plus2), .in_instr(in_instr), .flush(flush), .out_ready(out_ready),
    .out_valid(ov_0), .out_pc_plus2(pc_0), .out_ir(ir_0), .opcode(op_0), .dest(dst_0),
    .src1(sa_0), .src2(sb_0), .ir3(i3_0), .ir4(i4_0), .ir5(i5_0), .ir8(i8_0), .ir11(i11_0),
    .occupancy(occ_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference: per variant, a FIFO of capacity 2 (skid) or 1 (stall), plus last head data.
  int          cnt  [2];
  logic [15:0] q_pc [2][2];
  logic [15:0] q_ir [2][2];
  logic [15:0] h_pc [2];
  logic [15:0] h_ir [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_ready(input int k);
    if (k == 1) return cnt[k] < 2;
    return (cnt[k] == 0) || out_ready;
  endfunction

  task automatic check_inst(input int k, input logic rdy, input logic ov, input logic [1:0] occ,
                            input logic [15:0] pc, input logic [15:0] ir, input logic [3:0] op,
                            input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                            input logic [4:0] bits);
    string p;
    logic [15:0] e;
    p = (k == 1) ? "skid" : "stall";
    e = h_ir[k];
    check_eq({p, "_in_ready"}, 32'(rdy), 32'(exp_ready(k)));
    check_eq({p, "_out_valid"}, 32'(ov), 32'(cnt[k] > 0));
    check_eq({p, "_occupancy"}, 32'(occ), cnt[k]);
    check_eq({p, "_pc"}, 32'(pc), 32'(h_pc[k]));
    check_eq({p, "_ir"}, 32'(ir), 32'(e));
    check_eq({p, "_opcode"}, 32'(op), 32'(e >> 12));
    check_eq({p, "_regs"}, {23'd0, d, s1, s2}, {23'd0, e[11:9], e[8:6], e[2:0]});
    check_eq({p, "_bits"}, 32'(bits), {27'd0, e[11], e[8], e[5], e[4], e[3]});
  endtask

  task automatic model_step(input int k);
    logic acc, pop;
    acc = in_valid && exp_ready(k);
    pop = (cnt[k] > 0) && out_ready;
    if (reset) begin
      cnt[k]  = 0;
      h_pc[k] = '0;
      h_ir[k] = '0;
    end else if (flush) begin
      cnt[k] = 0;
    end else begin
      if (pop) begin
        q_pc[k][0] = q_pc[k][1];
        q_ir[k][0] = q_ir[k][1];
        cnt[k]--;
      end
      if (acc) begin
        q_pc[k][cnt[k]] = in_pc_plus2;
        q_ir[k][cnt[k]] = in_instr;
        cnt[k]++;
      end
      if (cnt[k] > 0) begin
        h_pc[k] = q_pc[k][0];
        h_ir[k] = q_ir[k][0];
      end
    end
  endtask

  // Drive one cycle of inputs, check both variants against the model, then advance it.
  task automatic cycle(input logic rs, input logic iv, input logic [15:0] pc,
                       input logic [15:0] ir, input logic fl, input logic ordy);
    @(negedge clk);
    reset       = rs;
    in_valid    = iv;
    in_pc_plus2 = pc;
    in_instr    = ir;
    flush       = fl;
    out_ready   = ordy;
    #1;
    if (chk_en) begin
      check_inst(1, rdy_1, ov_1, occ_1, pc_1, ir_1, op_1, dst_1, sa_1, sb_1,
                 {i11_1, i8_1, i5_1, i4_1, i3_1});
      check_inst(0, rdy_0, ov_0, occ_0, pc_0, ir_0, op_0, dst_0, sa_0, sb_0,
                 {i11_0, i8_0, i5_0, i4_0, i3_0});
    end
    model_step(1);
    model_step(0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc_plus2 = '0; in_instr = '0;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; h_pc[k] = '0; h_ir[k] = '0;
      q_pc[k][0] = '0; q_pc[k][1] = '0; q_ir[k][0] = '0; q_ir[k][1] = '0;
    end

    // Reset, then reset values
    cycle(1, 0, 16'h0, 16'h0, 0, 1);
    chk_en = 1'b1;
    cycle(0, 0, 16'h0, 16'h0, 0, 1);
    check_eq("rst_ready_skid", 32'(rdy_1), 32'd1);
    check_eq("rst_ready_stall", 32'(rdy_0), 32'd1);

    // Streaming with out_ready held high
    cycle(0, 1, 16'h1000, 16'h1283, 0, 1);
    cycle(0, 1, 16'h1002, 16'h5042, 0, 1);
    cycle(0, 1, 16'h1004, 16'h0E05, 0, 1);
    cycle(0, 0, 16'h0, 16'h0, 0, 1);

    // Stall: A in M, B offered while out_ready low, then drain
    cycle(0, 1, 16'h2000, 16'h1111, 0, 1);
    cycle(0, 1, 16'h2002, 16'h2222, 0, 0);
    cycle(0, 1, 16'h2004, 16'h3333, 0, 0);
    check_eq("full_occ_skid", 32'(occ_1), 32'd2);
    check_eq("full_ready_skid", 32'(rdy_1), 32'd0);
    cycle(0, 0, 16'h0, 16'h0, 0, 1);
    cycle(0, 0, 16'h0, 16'h0, 0, 1);
    cycle(0, 0, 16'h0, 16'h0, 0, 1);

    // Flush while full with a concurrent in_valid
    cycle(0, 1, 16'h3000, 16'h4444, 0, 1);
    cycle(0, 1, 16'h3002, 16'h5555, 0, 0);
    cycle(0, 1, 16'h3004, 16'h6666, 1, 0);
    cycle(0, 0, 16'h0, 16'h0, 0, 0);
    check_eq("flush_valid_skid", 32'(ov_1), 32'd0);
    check_eq("flush_valid_stall", 32'(ov_0), 32'd0);

    // Decode: ADD R1,R2,R3
    cycle(0, 1, 16'h4000, 16'h1283, 0, 0);
    cycle(0, 0, 16'h0, 16'h0, 0, 0);
    check_eq("add_opcode", 32'(op_1), 32'(OpAdd));
    check_eq("add_dest", 32'(dst_1), 32'd1);
    check_eq("add_src1", 32'(sa_1), 32'd2);
    check_eq("add_src2", 32'(sb_1), 32'd3);
    check_eq("add_ir5", 32'(i5_1), 32'd0);
    cycle(0, 0, 16'h0, 16'h0, 1, 0);
    cycle(0, 1, 16'h4002, 16'h0E05, 0, 0);
    cycle(0, 0, 16'h0, 16'h0, 0, 0);
    check_eq("br_ir11", 32'(i11_1), 32'd1);
    check_eq("br_opcode", 32'(op_1), 32'(OpBr));

    // Reset mid-stall with two entries, then normal flow
    cycle(0, 1, 16'h5000, 16'h7777, 0, 0);
    cycle(0, 1, 16'h5002, 16'h8888, 0, 0);
    cycle(1, 1, 16'h5004, 16'h9999, 0, 0);
    cycle(0, 1, 16'h5006, 16'hAAAA, 0, 1);
    check_eq("rst_mid_occ", 32'(occ_1), 32'd0);
    check_eq("rst_mid_ir", 32'(ir_1), 32'd0);
    cycle(0, 0, 16'h0, 16'h0, 0, 1);
    check_eq("post_rst_pc", 32'(pc_1), 32'h5006);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 16'($urandom),
            16'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
